// File: rtl/instr_fetch.sv
`default_nettype none
// ============================================================================
// Module      : instr_fetch
// Description : Fetch stage and IF/ID pipeline register. Holds the PC, issues
//               word fetches over a req/ready handshake, latches the returned
//               instruction and presents its decoded fields to the next stage.
//               Handles downstream stall and branch/jump redirect.
//               Optional performance counters are built when the macro
//               IFETCH_PERF_CNT_EN is defined; otherwise both counter ports
//               read as zero and no counter flops exist.
// Revision    : 1.0 - initial release
// ============================================================================
module instr_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        id_valid,
    output logic [31:0] id_instr,
    output logic [5:0]  id_opcode,
    output logic [5:0]  id_funct,
    output logic [4:0]  id_rs,
    output logic [4:0]  id_rt,
    output logic [4:0]  id_rd,
    output logic [15:0] id_imm,
    output logic [31:0] id_pc4,
    output logic        addr_err,
    output logic [31:0] fetch_count,
    output logic [31:0] stall_count
);

    localparam logic [1:0] S_BOOT  = 2'd0;
    localparam logic [1:0] S_FETCH = 2'd1;
    localparam logic [1:0] S_HOLD  = 2'd2;

    localparam logic [31:0] c_pc_step = 32'd4;

    logic [1:0]  r_state;
    logic [1:0]  w_next_state;
    logic        w_req;
    logic        w_accept;
    logic [31:0] w_pc_plus4;

    logic [31:0] r_pc;
    logic        r_id_valid;
    logic [31:0] r_id_instr;
    logic [31:0] r_id_pc4;
    logic        r_addr_err;

    assign w_pc_plus4 = r_pc + c_pc_step;
    // A fetch completes only when the request is handshaked and not squashed
    // by a simultaneous redirect.
    assign w_accept   = w_req && imem_ready && !redirect;

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_BOOT;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic; redirect always returns to fetching.
    always_comb begin
        w_next_state = r_state;
        if (redirect) begin
            w_next_state = S_FETCH;
        end else begin
            case (r_state)
                S_BOOT:  w_next_state = S_FETCH;
                S_FETCH: if (stall && r_id_valid) w_next_state = S_HOLD;
                S_HOLD:  if (!stall) w_next_state = S_FETCH;
                default: w_next_state = S_BOOT;
            endcase
        end
    end

    // Request output; a stall only blocks fetching when IF/ID holds a real
    // instruction, so a bubble is always refilled.
    always_comb begin
        w_req = 1'b0;
        if (r_state == S_FETCH) begin
            w_req = !(stall && r_id_valid);
        end
    end

    // PC and IF/ID register update.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc       <= RESET_PC;
            r_id_valid <= 1'b0;
            r_id_instr <= 32'h0;
            r_id_pc4   <= 32'h0;
            r_addr_err <= 1'b0;
        end else begin
            r_addr_err <= 1'b0;
            if (redirect) begin
                r_pc       <= {redirect_pc[31:2], 2'b00};
                r_id_valid <= 1'b0;
                r_id_instr <= 32'h0;
                r_id_pc4   <= 32'h0;
                r_addr_err <= |redirect_pc[1:0];
            end else if (w_accept) begin
                r_pc       <= w_pc_plus4;
                r_id_valid <= 1'b1;
                r_id_instr <= imem_rdata;
                r_id_pc4   <= w_pc_plus4;
            end else if ((w_req) || (r_state == S_HOLD && !stall)) begin
                // Wait state, or leaving HOLD: downstream consumes the held
                // instruction this cycle and nothing new arrived, so a bubble
                // is inserted to avoid presenting it twice.
                r_id_valid <= 1'b0;
                r_id_instr <= 32'h0;
                r_id_pc4   <= 32'h0;
            end
        end
    end

`ifdef IFETCH_PERF_CNT_EN
    logic        w_stalled;
    logic [31:0] r_fetch_count;
    logic [31:0] r_stall_count;

    assign w_stalled = (r_state == S_HOLD) ||
                       ((r_state == S_FETCH) && stall && r_id_valid);

    // Accepted-fetch and stalled-cycle counters, free-running modulo 2^32.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_fetch_count <= 32'h0;
            r_stall_count <= 32'h0;
        end else begin
            if (w_accept) begin
                r_fetch_count <= r_fetch_count + 32'd1;
            end
            if (w_stalled) begin
                r_stall_count <= r_stall_count + 32'd1;
            end
        end
    end

    assign fetch_count = r_fetch_count;
    assign stall_count = r_stall_count;
`else
    assign fetch_count = 32'h0;
    assign stall_count = 32'h0;
`endif

    assign imem_req  = w_req;
    assign imem_addr = r_pc;
    assign id_valid  = r_id_valid;
    assign id_instr  = r_id_instr;
    assign id_opcode = r_id_instr[31:26];
    assign id_rs     = r_id_instr[25:21];
    assign id_rt     = r_id_instr[20:16];
    assign id_rd     = r_id_instr[15:11];
    assign id_imm    = r_id_instr[15:0];
    assign id_funct  = r_id_instr[5:0];
    assign id_pc4    = r_id_pc4;
    assign addr_err  = r_addr_err;

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch.sv
`default_nettype none
// ============================================================================
// Module      : tb_instr_fetch
// Description : Self-checking bench for instr_fetch. Memory returns addr>>2.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_instr_fetch;

    localparam logic [31:0] P = 32'h0040_0000;

    logic        clk = 1'b0;
    logic        reset, imem_req, imem_ready, stall, redirect;
    logic [31:0] imem_addr, imem_rdata, redirect_pc;
    logic        id_valid, addr_err;
    logic [31:0] id_instr, id_pc4, fetch_count, stall_count;
    logic [5:0]  id_opcode, id_funct;
    logic [4:0]  id_rs, id_rt, id_rd;
    logic [15:0] id_imm;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    assign imem_rdata = imem_addr >> 2;

    instr_fetch #(.RESET_PC(P)) dut (
        .clk(clk), .reset(reset),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ready(imem_ready), .imem_rdata(imem_rdata),
        .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
        .id_valid(id_valid), .id_instr(id_instr),
        .id_opcode(id_opcode), .id_funct(id_funct),
        .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .id_imm(id_imm),
        .id_pc4(id_pc4), .addr_err(addr_err),
        .fetch_count(fetch_count), .stall_count(stall_count)
    );

    typedef struct {
        logic        stall;
        logic        redirect;
        logic        ready;
        logic [31:0] rpc;
        logic        e_valid;
        logic [31:0] e_instr;
        logic [31:0] e_pc4;
        logic [31:0] e_addr;
        logic        e_req;
        logic        e_err;
    } vec_t;

    vec_t vt[18];

    function automatic vec_t mk(logic s, logic r, logic rdy, logic [31:0] rpc,
                                logic v, logic [31:0] ins, logic [31:0] pc4,
                                logic [31:0] addr, logic req, logic err);
        vec_t x;
        x.stall = s; x.redirect = r; x.ready = rdy; x.rpc = rpc;
        x.e_valid = v; x.e_instr = ins; x.e_pc4 = pc4; x.e_addr = addr;
        x.e_req = req; x.e_err = err;
        return x;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [31:0] e;
        // stall, redirect, ready, rpc | valid, instr, pc4, addr, req, err
        vt[0]  = mk(0,0,1,0,      1, 32'h0010_0000, P+4,  P+4,  1, 0);
        vt[1]  = mk(0,0,1,0,      1, 32'h0010_0001, P+8,  P+8,  1, 0);
        vt[2]  = mk(0,0,1,0,      1, 32'h0010_0002, P+12, P+12, 1, 0);
        vt[3]  = mk(1,0,1,0,      1, 32'h0010_0002, P+12, P+12, 0, 0);
        vt[4]  = mk(1,0,1,0,      1, 32'h0010_0002, P+12, P+12, 0, 0);
        vt[5]  = mk(1,0,1,0,      1, 32'h0010_0002, P+12, P+12, 0, 0);
        vt[6]  = mk(0,0,1,0,      0, 32'h0,         32'h0, P+12, 1, 0);
        vt[7]  = mk(0,0,1,0,      1, 32'h0010_0003, P+16, P+16, 1, 0);
        vt[8]  = mk(0,0,0,0,      0, 32'h0,         32'h0, P+16, 1, 0);
        vt[9]  = mk(0,0,0,0,      0, 32'h0,         32'h0, P+16, 1, 0);
        vt[10] = mk(0,0,1,0,      1, 32'h0010_0004, P+20, P+20, 1, 0);
        vt[11] = mk(0,0,0,0,      0, 32'h0,         32'h0, P+20, 1, 0);
        vt[12] = mk(1,0,1,0,      1, 32'h0010_0005, P+24, P+24, 0, 0);
        vt[13] = mk(1,1,1,32'h103,0, 32'h0,         32'h0, 32'h100, 1, 1);
        vt[14] = mk(0,0,1,0,      1, 32'h0000_0040, 32'h104, 32'h104, 1, 0);
        vt[15] = mk(0,1,1,32'hFFFF_FFFC, 0, 32'h0,  32'h0, 32'hFFFF_FFFC, 1, 0);
        vt[16] = mk(0,0,1,0,      1, 32'h3FFF_FFFF, 32'h0, 32'h0, 1, 0);
        vt[17] = mk(0,0,1,0,      1, 32'h0,         32'h4, 32'h4, 1, 0);

        // Reset held for three cycles.
        reset = 1'b1; stall = 1'b0; redirect = 1'b0; imem_ready = 1'b0;
        redirect_pc = 32'h0;
        repeat (3) tick();
        chk("rst_valid", {31'h0, id_valid}, 32'h0);
        chk("rst_instr", id_instr, 32'h0);
        chk("rst_fields", {id_opcode, id_rs, id_rt, id_imm}, 32'h0);
        chk("rst_pc4", id_pc4, 32'h0);
        chk("rst_req", {31'h0, imem_req}, 32'h0);
        chk("rst_err", {31'h0, addr_err}, 32'h0);
        chk("rst_fcnt", fetch_count, 32'h0);
        chk("rst_scnt", stall_count, 32'h0);
        chk("rst_addr", imem_addr, P);

        reset = 1'b0;
        #1;
        chk("boot_req", {31'h0, imem_req}, 32'h0);
        tick();
        chk("first_req", {31'h0, imem_req}, 32'h1);
        chk("first_addr", imem_addr, P);

        // Directed vector table.
        for (int i = 0; i < 18; i++) begin
            stall = vt[i].stall; redirect = vt[i].redirect;
            imem_ready = vt[i].ready; redirect_pc = vt[i].rpc;
            tick();
            e = vt[i].e_instr;
            chk($sformatf("v%0d_valid", i), {31'h0, id_valid}, {31'h0, vt[i].e_valid});
            chk($sformatf("v%0d_instr", i), id_instr, e);
            chk($sformatf("v%0d_fields", i), {id_opcode, id_rs, id_rt, id_imm}, e);
            chk($sformatf("v%0d_rdfn", i), {21'h0, id_rd, id_funct}, {21'h0, e[15:11], e[5:0]});
            chk($sformatf("v%0d_pc4", i), id_pc4, vt[i].e_pc4);
            chk($sformatf("v%0d_addr", i), imem_addr, vt[i].e_addr);
            chk($sformatf("v%0d_req", i), {31'h0, imem_req}, {31'h0, vt[i].e_req});
            chk($sformatf("v%0d_err", i), {31'h0, addr_err}, {31'h0, vt[i].e_err});
        end
`ifdef IFETCH_PERF_CNT_EN
        chk("tbl_fcnt", fetch_count, 32'd9);
        chk("tbl_scnt", stall_count, 32'd5);
`else
        chk("tbl_fcnt", fetch_count, 32'd0);
        chk("tbl_scnt", stall_count, 32'd0);
`endif

        // Reset overrides a simultaneous misaligned redirect, stall and fetch.
        reset = 1'b1; redirect = 1'b1; redirect_pc = 32'h9; stall = 1'b1; imem_ready = 1'b1;
        tick();
        chk("mid_rst_valid", {31'h0, id_valid}, 32'h0);
        chk("mid_rst_addr", imem_addr, P);
        chk("mid_rst_req", {31'h0, imem_req}, 32'h0);
        chk("mid_rst_err", {31'h0, addr_err}, 32'h0);
        chk("mid_rst_fcnt", fetch_count, 32'h0);

        // PC wrap from the top of the address space.
        reset = 1'b0; redirect = 1'b0; stall = 1'b0; imem_ready = 1'b0;
        tick();
        redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC;
        tick();
        chk("wrap_addr0", imem_addr, 32'hFFFF_FFFC);
        redirect = 1'b0; imem_ready = 1'b1;
        tick();
        chk("wrap_addr1", imem_addr, 32'h0);
        chk("wrap_pc4", id_pc4, 32'h0);
        chk("wrap_err", {31'h0, addr_err}, 32'h0);
        tick();
        chk("wrap_instr", id_instr, 32'h0);
        chk("wrap_addr2", imem_addr, 32'h4);
`ifdef IFETCH_PERF_CNT_EN
        chk("wrap_fcnt", fetch_count, 32'd2);
`else
        chk("wrap_fcnt", fetch_count, 32'd0);
`endif
        chk("wrap_scnt", stall_count, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
